ula_sched: RTL and testbench

Two-client scheduler that shares one 8-bit ALU datapath between two requesters. It arbitrates round-robin, captures the winner's opcode and operands, computes one result per transaction and returns it through a response handshake tagged with the requester ID. It sits between the instruction-issue logic and the arithmetic datapath. It is the only path by which the datapath is used.

---
 rtl/ula_pkg.sv | 49 ++++
 rtl/rr_arb2.sv | 25 ++
 rtl/ula_sched.sv | 99 +++++++++
 tb/tb_ula_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and the ALU evaluation function for the two-client ALU scheduler.
// alu_eval works at ALU_W bits; callers zero-extend operands and truncate the result.
package ula_pkg;

  localparam int DW_DEF  = 8;
  localparam int OPW_DEF = 3;
  localparam int ALU_W   = 32;

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_ADD     = 3'b010,
    OP_ILLEGAL = 3'b011,
    OP_ANDN    = 3'b100,
    OP_ORN     = 3'b101,
    OP_SUB     = 3'b110,
    OP_GTU     = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Returns {err, result}. Truncating the result to the caller's width keeps
  // add/sub wrapping modulo 2^DW and the inverted forms correct.
  function automatic logic [ALU_W:0] alu_eval(input logic [2:0] op,
                                              input logic [ALU_W-1:0] a,
                                              input logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] r;
    logic             err;
    r   = '0;
    err = 1'b0;
    case (opcode_t'(op))
      OP_AND:     r = a & b;
      OP_OR:      r = a | b;
      OP_ADD:     r = a + b;
      OP_ANDN:    r = a & ~b;
      OP_ORN:     r = a | ~b;
      OP_SUB:     r = a - b;
      OP_GTU:     r = {{(ALU_W-1){1'b0}}, (a > b)};
      OP_ILLEGAL: err = 1'b1;
      default:    err = 1'b1;
    endcase
    return {err, r};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on contention the client that did not win last
// is granted; a lone requester always wins. last_grant moves only on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant = valid;
    if (&valid) grant = last_grant ? 2'b01 : 2'b10;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end

endmodule

// File: rtl/ula_sched.sv
// Two-client scheduler sharing one ALU: IDLE accepts a request, EXEC computes,
// RESP holds the tagged result until the consumer takes it.
module ula_sched
  import ula_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  output logic [15:0]    ops_done
);

  state_t         state_q, state_d;
  logic [1:0]     grant;
  logic           idle;
  logic           accept;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q;
  logic [DW-1:0]  res_d;
  logic           err_d;

  // Gating with rst_n keeps both ready outputs low while reset is held.
  assign idle       = rst_n && (state_q == IDLE);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign rsp_valid  = (state_q == RESP);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    res_d = DW'(alu_eval(3'(op_q), ALU_W'(a_q), ALU_W'(b_q)));
    err_d = 1'(alu_eval(3'(op_q), ALU_W'(a_q), ALU_W'(b_q)) >> ALU_W);
  end

  // NOTE: operand and result registers are reset as well, so a discarded op leaves
  // no stale data visible on rsp_data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        op_q   <= grant[1] ? req1_op : req0_op;
        a_q    <= grant[1] ? req1_a  : req0_a;
        b_q    <= grant[1] ? req1_b  : req0_b;
        rsp_id <= grant[1];
      end
      if (state_q == EXEC) begin
        rsp_data <= res_d;
        rsp_err  <= err_d;
      end
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_ula_sched.sv
// Self-checking bench for ula_sched: opcode table, arbitration/stall/reset
// sequences, then randomized traffic against a transaction-level model.
module tb_ula_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0]  rsp_data;
  logic [15:0] ops_done;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_ops  = '0;

  always #5 clk = ~clk;

  ula_sched #(.DW(8), .OPW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ops_done   (ops_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the opcode table, 8-bit wrapping arithmetic.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return {1'b0, a & b};
      3'b001:  return {1'b0, a | b};
      3'b010:  return {1'b0, 8'(a + b)};
      3'b100:  return {1'b0, a & ~b};
      3'b101:  return {1'b0, a | ~b};
      3'b110:  return {1'b0, 8'(a - b)};
      3'b111:  return {1'b0, (a > b) ? 8'd1 : 8'd0};
      default: return {1'b1, 8'd0};
    endcase
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_ready(input bit id, output int w);
    w = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) return;
      w++;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) return;
    end
    lat = 99;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ops = '0;
  endtask

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [7:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat;
    int g_id[$], g_cyc[$], r_id[$];
    logic [7:0] r_data[$];
    logic [7:0] hold_data;
    // random-phase model state
    bit         pend[2];
    logic [2:0] pop[2];
    logic [7:0] pa[2], pb[2];
    bit         outst, last;
    int         cyc, due, next_free, ew;
    logic [8:0] exp_rsp;
    logic       exp_id;

    vecs[0] = '{1'b0, 3'b010, 8'hF0, 8'h20, 8'h10, 1'b0};
    vecs[1] = '{1'b0, 3'b110, 8'h05, 8'h07, 8'hFE, 1'b0};
    vecs[2] = '{1'b1, 3'b111, 8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[3] = '{1'b0, 3'b111, 8'h5A, 8'h5A, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 3'b000, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[5] = '{1'b0, 3'b001, 8'hCC, 8'hAA, 8'hEE, 1'b0};
    vecs[6] = '{1'b1, 3'b100, 8'hCC, 8'hAA, 8'h44, 1'b0};
    vecs[7] = '{1'b0, 3'b101, 8'hCC, 8'hAA, 8'hDD, 1'b0};
    vecs[8] = '{1'b0, 3'b010, 8'hFF, 8'h02, 8'h01, 1'b0};
    vecs[9] = '{1'b1, 3'b011, 8'h12, 8'h34, 8'h00, 1'b1};

    // Reset with a request already present: ready must stay low.
    rst_n = 1'b0; rsp_ready = 1'b0;
    set_req(0, 1, 3'b000, 8'h00, 8'h00);
    set_req(1, 0, 3'b000, 8'h00, 8'h00);
    #12;
    check("reset_ready0", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_ops_done", ops_done, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Opcode table, one transaction at a time.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      set_req(vecs[i].id, 1, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_ready(vecs[i].id, w);
      check("vec_accept_wait", w, 0);
      check("vec_other_ready", vecs[i].id ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      set_req(vecs[i].id, 0, 3'b000, 8'h00, 8'h00);
      wait_rsp(lat);
      check("vec_latency", lat, 2);
      check("vec_data", rsp_data, vecs[i].data);
      check("vec_err", rsp_err, vecs[i].err);
      check("vec_id", rsp_id, vecs[i].id);
      exp_ops++;
      @(negedge clk);
      check("vec_ops_done", ops_done, exp_ops);
    end

    // Both clients valid continuously: grants alternate, one op per 3 cycles.
    @(posedge clk); #1;
    set_req(0, 1, 3'b010, 8'h01, 8'h02);
    set_req(1, 1, 3'b010, 8'h03, 8'h04);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("rr_both_ready", 1, 0);
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
      if (rsp_valid) begin r_id.push_back(rsp_id); r_data.push_back(rsp_data); end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_grant_count", g_id.size(), 4);
    check("rr_rsp_count", r_id.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_id.size()) begin
        check("rr_grant_order", g_id[i], i % 2);
        if (i > 0) check("rr_grant_gap", g_cyc[i] - g_cyc[i-1], 3);
      end
      if (i < r_id.size() && i < g_id.size()) begin
        check("rr_rsp_id", r_id[i], g_id[i]);
        check("rr_rsp_data", r_data[i], (g_id[i] != 0) ? 8'h07 : 8'h03);
      end
    end
    exp_ops += 16'(r_id.size());
    @(negedge clk);
    check("rr_ops_done", ops_done, exp_ops);

    // Stall in RESP for 10 cycles while client 1 waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 1, 3'b110, 8'h10, 8'h01);
    wait_ready(0, w);
    check("stall_accept_wait", w, 0);
    @(posedge clk); #1;
    set_req(0, 0, 3'b000, 8'h00, 8'h00);
    set_req(1, 1, 3'b001, 8'h30, 8'h03);
    wait_rsp(lat);
    check("stall_latency", lat, 2);
    hold_data = rsp_data;
    check("stall_data", hold_data, 8'h0F);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data_hold", rsp_data, 8'h0F);
      check("stall_id_hold", rsp_id, 0);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1", req1_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready1_resp", req1_ready, 0);
    @(negedge clk);
    exp_ops++;
    check("stall_release_ready1", req1_ready, 1);
    check("stall_release_ready0", req0_ready, 0);
    check("stall_ops_done", ops_done, exp_ops);
    @(posedge clk); #1;
    set_req(1, 0, 3'b000, 8'h00, 8'h00);
    wait_rsp(lat);
    check("stall_c1_latency", lat, 2);
    check("stall_c1_data", rsp_data, 8'h33);
    check("stall_c1_id", rsp_id, 1);
    exp_ops++;
    @(negedge clk);
    check("stall_c1_ops_done", ops_done, exp_ops);

    // Reset during EXEC: op discarded, outputs cleared asynchronously,
    // and contention afterwards goes to client 0 even though it won last.
    @(posedge clk); #1;
    set_req(0, 1, 3'b010, 8'h01, 8'h01);
    wait_ready(0, w);
    check("rst_accept_wait", w, 0);
    @(posedge clk); #1;
    set_req(0, 0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_exec_valid", rsp_valid, 0);
    #1 rst_n = 1'b0;
    set_req(0, 1, 3'b010, 8'h01, 8'h01);
    set_req(1, 1, 3'b010, 8'h02, 8'h02);
    #1;
    check("rst_async_valid", rsp_valid, 0);
    check("rst_async_data", rsp_data, 0);
    check("rst_async_id", rsp_id, 0);
    check("rst_async_err", rsp_err, 0);
    check("rst_async_ops", ops_done, 0);
    check("rst_async_ready0", req0_ready, 0);
    check("rst_async_ready1", req1_ready, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_hold_valid", rsp_valid, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_ops = '0;
    @(negedge clk);
    check("rst_after_ready0", req0_ready, 1);
    check("rst_after_ready1", req1_ready, 0);
    check("rst_after_valid", rsp_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    check("rst_after_latency", lat, 2);
    check("rst_after_id", rsp_id, 0);
    check("rst_after_data", rsp_data, 8'h02);
    exp_ops++;
    @(negedge clk);
    check("rst_after_ops", ops_done, exp_ops);

    // Randomized traffic against a transaction-level model.
    reset_pulse();
    pend[0] = 0; pend[1] = 0;
    outst = 0; last = 1; cyc = 0; due = 0; next_free = 0;
    exp_rsp = '0; exp_id = 0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && ($urandom_range(1, 0) == 1)) begin
          pend[c] = 1;
          pop[c] = 3'($urandom);
          pa[c]  = 8'($urandom);
          pb[c]  = 8'($urandom);
        end
      end
      set_req(0, pend[0], pop[0], pa[0], pb[0]);
      set_req(1, pend[1], pop[1], pa[1], pb[1]);
      rsp_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      ew = -1;
      if (!outst && cyc >= next_free) begin
        if (pend[0] && pend[1]) ew = last ? 0 : 1;
        else if (pend[0])       ew = 0;
        else if (pend[1])       ew = 1;
      end
      check("rnd_ready0", req0_ready, (ew == 0));
      check("rnd_ready1", req1_ready, (ew == 1));
      check("rnd_rsp_valid", rsp_valid, (outst && cyc >= due));
      if (outst && cyc >= due) begin
        check("rnd_rsp_id", rsp_id, exp_id);
        check("rnd_rsp_data", rsp_data, exp_rsp[7:0]);
        check("rnd_rsp_err", rsp_err, exp_rsp[8]);
      end
      check("rnd_ops_done", ops_done, exp_ops);
      if (ew >= 0) begin
        outst   = 1;
        due     = cyc + 2;
        exp_id  = (ew == 1);
        exp_rsp = ref_alu(pop[ew], pa[ew], pb[ew]);
        last    = (ew == 1);
        pend[ew] = 0;
      end else if (outst && cyc >= due && rsp_ready) begin
        outst     = 0;
        next_free = cyc + 1;
        exp_ops++;
      end
      cyc++;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
